// File: rtl/sdram_test_status.sv
// Status-line consumer for the SDRAM tester: registers ready/running/error, tracks
// wait/idle/run/error-hold, counts errors and passes, and drives a two-LED blink code.
module sdram_test_status #(
    parameter int BLINK_BITS = 24,
    parameter int HOLD_BITS  = 27
) (
    input  logic       clock,
    input  logic       init,
    input  logic       ready,
    input  logic       running,
    input  logic       error,
    output logic [1:0] led,
    output logic       failed,
    output logic [7:0] errorCount,
    output logic [7:0] passCount
);

    typedef enum logic [1:0] {
        S_WAIT,
        S_IDLE,
        S_RUN,
        S_ERRHOLD
    } state_t;

    state_t                state, state_next;
    logic                  ready_q, running_q, error_q, running_qq, error_qq;
    logic                  err_edge, pass_edge;
    logic [BLINK_BITS-1:0] bc;
    logic                  blink;
    logic [HOLD_BITS-1:0]  hold_cnt;
    logic                  hold_done;

    // NOTE: every flop below is written with <= so all registers update from the
    // same pre-edge values; blocking here would let later statements see new values.
    always_ff @(posedge clock or negedge init) begin
        if (!init) begin
            ready_q    <= 1'b0;
            running_q  <= 1'b0;
            error_q    <= 1'b0;
            running_qq <= 1'b0;
            error_qq   <= 1'b0;
        end else begin
            ready_q    <= ready;
            running_q  <= running;
            error_q    <= error;
            running_qq <= running_q;
            error_qq   <= error_q;
        end
    end

    // Edges are qualified by ready_q, so a ready rise with error already high never counts.
    assign err_edge  = ready_q & error_q & ~error_qq;
    assign pass_edge = ready_q & running_qq & ~running_q;

    always_ff @(posedge clock or negedge init) begin
        if (!init) begin
            bc <= '0;
        end else begin
            bc <= bc + 1'b1;
        end
    end

    assign blink = bc[BLINK_BITS-1];

    // Hold counter freezes while ready is low; state leaves ERRHOLD then anyway.
    always_ff @(posedge clock or negedge init) begin
        if (!init) begin
            hold_cnt <= '0;
        end else if (ready_q) begin
            if (err_edge) begin
                hold_cnt <= '0;
            end else if (state == S_ERRHOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign hold_done = &hold_cnt;

    always_ff @(posedge clock or negedge init) begin
        if (!init) begin
            state <= S_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (!ready_q) begin
            state_next = S_WAIT;
        end else if (err_edge) begin
            state_next = S_ERRHOLD;
        end else if (state == S_ERRHOLD) begin
            if (hold_done) begin
                state_next = running_q ? S_RUN : S_IDLE;
            end
        end else begin
            state_next = running_q ? S_RUN : S_IDLE;
        end
    end

    always_comb begin
        led = 2'b00;
        unique case (state)
            S_WAIT:    led = 2'b00;
            S_IDLE:    led = failed ? 2'b10 : 2'b01;
            S_RUN:     led = failed ? {blink, 1'b0} : {blink, ~blink};
            S_ERRHOLD: led = {blink, blink};
            default:   led = 2'b00;
        endcase
    end

    // Counters and the fail flag survive WAIT; only init clears them.
    always_ff @(posedge clock or negedge init) begin
        if (!init) begin
            failed     <= 1'b0;
            errorCount <= 8'd0;
            passCount  <= 8'd0;
        end else begin
            if (err_edge) begin
                failed <= 1'b1;
                if (errorCount != 8'hFF) begin
                    errorCount <= errorCount + 8'd1;
                end
            end
            if (pass_edge) begin
                passCount <= passCount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_test_status.sv
// Bench for sdram_test_status: directed scenarios plus random status traffic, checked
// each cycle against a behavioural model of the LED code and counters.
module tb_sdram_test_status;

    localparam int BLINK_BITS  = 3;
    localparam int HOLD_BITS   = 4;
    localparam int HOLD_CYCLES = 1 << HOLD_BITS;
    localparam int BLINK_MOD   = 1 << BLINK_BITS;

    logic       clock = 1'b0;
    logic       init;
    logic       ready, running, error;
    logic [1:0] led;
    logic       failed;
    logic [7:0] errorCount, passCount;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    sdram_test_status #(
        .BLINK_BITS(BLINK_BITS),
        .HOLD_BITS (HOLD_BITS)
    ) dut (
        .clock     (clock),
        .init      (init),
        .ready     (ready),
        .running   (running),
        .error     (error),
        .led       (led),
        .failed    (failed),
        .errorCount(errorCount),
        .passCount (passCount)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode plus a countdown of remaining hold cycles and an edge count for blink.
    typedef enum {M_WAIT, M_IDLE, M_RUN, M_HOLD} mode_t;
    mode_t m_mode;
    int    m_hold_left, m_edges, m_ecnt, m_pcnt;
    bit    m_fail, m_rq, m_rnq, m_eq, m_rnqq, m_eqq, m_err, m_pass;

    always @(posedge clock or negedge init) begin
        if (!init) begin
            m_mode = M_WAIT; m_hold_left = 0; m_edges = 0; m_ecnt = 0; m_pcnt = 0;
            m_fail = 0; m_rq = 0; m_rnq = 0; m_eq = 0; m_rnqq = 0; m_eqq = 0;
        end else begin
            m_err  = m_rq && m_eq && !m_eqq;
            m_pass = m_rq && m_rnqq && !m_rnq;
            if (m_err) begin
                m_fail = 1;
                if (m_ecnt < 255) m_ecnt++;
            end
            if (m_pass) m_pcnt = (m_pcnt + 1) % 256;
            if (!m_rq) m_mode = M_WAIT;
            else if (m_err) begin
                m_mode = M_HOLD;
                m_hold_left = HOLD_CYCLES;
            end else if (m_mode == M_HOLD) begin
                m_hold_left--;
                if (m_hold_left == 0) m_mode = m_rnq ? M_RUN : M_IDLE;
            end else m_mode = m_rnq ? M_RUN : M_IDLE;
            m_edges++;
            m_eqq = m_eq; m_rnqq = m_rnq;
            m_rq = ready; m_rnq = running; m_eq = error;
        end
    end

    function automatic logic [1:0] model_led();
        bit b;
        b = (m_edges % BLINK_MOD) >= (BLINK_MOD / 2);
        case (m_mode)
            M_IDLE:  return m_fail ? 2'b10 : 2'b01;
            M_RUN:   return m_fail ? {b, 1'b0} : {b, ~b};
            M_HOLD:  return {b, b};
            default: return 2'b00;
        endcase
    endfunction

    always @(negedge clock) begin
        if (cmp_en) begin
            check("led", led, model_led());
            check("failed", failed, m_fail);
            check("errorCount", errorCount, m_ecnt);
            check("passCount", passCount, m_pcnt);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic pulse_error();
        error = 1'b1;
        tick(1);
        error = 1'b0;
        tick(1);
    endtask

    task automatic pulse_running();
        running = 1'b1;
        tick(1);
        running = 1'b0;
        tick(1);
    endtask

    int n11;

    initial begin
        init = 1'b0; ready = 1'b1; running = 1'b0; error = 1'b0;
        tick(1);
        cmp_en = 1;

        // 1. reset and idle
        tick(4);
        check("reset_led", led, 2'b00);
        init = 1'b1;
        tick(2);
        check("idle_led", led, 2'b01);
        check("idle_counts", {errorCount, passCount}, 16'h0000);

        // 2. run blink then pass
        running = 1'b1;
        tick(20);
        running = 1'b0;
        tick(2);
        check("pass_count_1", passCount, 8'd1);
        check("pass_led", led, 2'b01);

        // 3. single error in RUN: hold is 16 cycles, half of them show 11
        running = 1'b1;
        tick(10);
        error = 1'b1;
        tick(1);
        error = 1'b0;
        n11 = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (led == 2'b11) n11++;
        end
        check("hold_11_cycles", n11, 8);
        check("err_count_1", errorCount, 8'd1);
        check("failed_set", failed, 1'b1);

        // 4. retrigger at hold cycle 10, then a level error (cumulative count continues)
        pulse_error();
        tick(9);
        pulse_error();
        tick(30);
        check("err_count_retrig", errorCount, 8'd3);
        error = 1'b1;
        tick(40);
        error = 1'b0;
        tick(25);
        check("err_count_level", errorCount, 8'd4);

        // 5. saturation and wrap from a fresh reset
        running = 1'b0;
        init = 1'b0;
        tick(3);
        init = 1'b1;
        tick(3);
        for (int i = 0; i < 300; i++) pulse_error();
        tick(2);
        check("err_saturate", errorCount, 8'd255);
        for (int i = 0; i < 257; i++) pulse_running();
        tick(2);
        check("pass_wrap", passCount, 8'd1);

        // 6. ready drop during hold, then async reset between edges
        pulse_error();
        tick(3);
        ready = 1'b0;
        tick(2);
        check("ready_drop_led", led, 2'b00);
        check("ready_drop_keep", errorCount, 8'd255);
        tick(2);
        init = 1'b0;
        #1;
        check("async_rst_outs", {led, failed, errorCount, passCount}, 19'd0);
        tick(3);

        // random status traffic
        init = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            ready = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 7) == 0) running = ~running;
            error = ($urandom_range(0, 9) == 0);
            tick(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
